// File: rtl/tcp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tcp_tx_arbiter
//
// Purpose:
//   Shares one tcp_to_stream TCP transmit converter between NUM_SRC segment
//   producers (data TX engine, pure-ACK generator, ...). One requester is
//   granted at a time and keeps the grant from header acceptance until the
//   final payload beat, or until header acceptance for header-only segments.
//   While granted, the winner's header and data handshakes are muxed
//   combinationally onto the converter-side ports.
//
// Configuration macro:
//   TCP_TX_ARB_STRICT_PRIO_EN - when defined, fixed priority (lowest index
//                               wins) replaces round-robin and the
//                               round-robin pointer is not built.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   src_arb_hdr_val            per-source header valid
//   src_arb_src_ip_addr        per-source source IP (slice i = source i)
//   src_arb_dst_ip_addr        per-source destination IP
//   src_arb_tcp_len            per-source TCP header + payload length (bytes)
//   src_arb_tcp_hdr            per-source packed tcp_pkt_hdr_t
//   arb_src_hdr_rdy            per-source header ready
//   src_arb_data_val/_data/_data_last/_data_padbytes   per-source data beat
//   arb_src_data_rdy           per-source data ready
//   arb_dst_hdr_val ... dst_arb_hdr_rdy   header channel to converter
//   arb_dst_data_val ... dst_arb_data_rdy data channel to converter
//   arb_grant_oh               registered one-hot grant, zero when idle
//   arb_busy                   high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------

package tcp_tx_arbiter_pkg;

  localparam int IP_ADDR_W       = 32;
  localparam int TOT_LEN_W       = 16;
  localparam int MAC_INTERFACE_W = 256;
  localparam int MAC_PADBYTES_W  = $clog2(MAC_INTERFACE_W / 8);

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  raw_data_offset;
    logic [2:0]  reserved;
    logic [8:0]  flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_ptr;
  } tcp_pkt_hdr_t;

  localparam int TCP_HDR_W = $bits(tcp_pkt_hdr_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

module tcp_tx_arbiter
  import tcp_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic                                       clk,
  input  logic                                       rst,

  input  logic [NUM_SRC-1:0]                         src_arb_hdr_val,
  input  logic [NUM_SRC-1:0][IP_ADDR_W-1:0]          src_arb_src_ip_addr,
  input  logic [NUM_SRC-1:0][IP_ADDR_W-1:0]          src_arb_dst_ip_addr,
  input  logic [NUM_SRC-1:0][TOT_LEN_W-1:0]          src_arb_tcp_len,
  input  logic [NUM_SRC-1:0][TCP_HDR_W-1:0]          src_arb_tcp_hdr,
  output logic [NUM_SRC-1:0]                         arb_src_hdr_rdy,

  input  logic [NUM_SRC-1:0]                         src_arb_data_val,
  input  logic [NUM_SRC-1:0][MAC_INTERFACE_W-1:0]    src_arb_data,
  input  logic [NUM_SRC-1:0]                         src_arb_data_last,
  input  logic [NUM_SRC-1:0][MAC_PADBYTES_W-1:0]     src_arb_data_padbytes,
  output logic [NUM_SRC-1:0]                         arb_src_data_rdy,

  output logic                                       arb_dst_hdr_val,
  output logic [IP_ADDR_W-1:0]                       arb_dst_src_ip_addr,
  output logic [IP_ADDR_W-1:0]                       arb_dst_dst_ip_addr,
  output logic [TOT_LEN_W-1:0]                       arb_dst_tcp_len,
  output logic [TCP_HDR_W-1:0]                       arb_dst_tcp_hdr,
  input  logic                                       dst_arb_hdr_rdy,

  output logic                                       arb_dst_data_val,
  input  logic                                       dst_arb_data_rdy,
  output logic [MAC_INTERFACE_W-1:0]                 arb_dst_data,
  output logic                                       arb_dst_data_last,
  output logic [MAC_PADBYTES_W-1:0]                  arb_dst_data_padbytes,

  output logic [NUM_SRC-1:0]                         arb_grant_oh,
  output logic                                       arb_busy
);

  arb_state_e             state_reg, state_nxt;
  logic [NUM_SRC-1:0]     grant_oh_reg, grant_oh_nxt;
  logic [SRC_IDX_W-1:0]   grant_idx_reg, grant_idx_nxt;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
  logic [SRC_IDX_W-1:0]   rr_ptr_reg, rr_ptr_nxt;
`endif

  logic                   win_found;
  logic [SRC_IDX_W-1:0]   win_idx;
  tcp_pkt_hdr_t           hdr_sel;
  logic [TOT_LEN_W-1:0]   payload_len;
  int                     cand;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would create
  // order-dependent simulation and a mismatch against the synthesized netlist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      grant_oh_reg  <= '0;
      grant_idx_reg <= '0;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
      rr_ptr_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_nxt;
      grant_oh_reg  <= grant_oh_nxt;
      grant_idx_reg <= grant_idx_nxt;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
      rr_ptr_reg    <= rr_ptr_nxt;
`endif
    end
  end

  assign arb_grant_oh = grant_oh_reg;
  assign arb_busy     = (state_reg != ST_IDLE);

  // Winner search: scan all sources starting at the pointer (round-robin) or
  // at index 0 (strict priority); the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef TCP_TX_ARB_STRICT_PRIO_EN
      cand = i;
`else
      cand = int'(rr_ptr_reg) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
`endif
      if (!win_found && src_arb_hdr_val[SRC_IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = SRC_IDX_W'(cand);
      end
    end
  end

  // The payload length decides whether the segment is header-only.
  assign hdr_sel     = tcp_pkt_hdr_t'(src_arb_tcp_hdr[grant_idx_reg]);
  assign payload_len = src_arb_tcp_len[grant_idx_reg]
                     - TOT_LEN_W'({hdr_sel.raw_data_offset, 2'b00});

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt             = state_reg;
    grant_oh_nxt          = grant_oh_reg;
    grant_idx_nxt         = grant_idx_reg;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
    rr_ptr_nxt            = rr_ptr_reg;
`endif
    arb_src_hdr_rdy       = '0;
    arb_src_data_rdy      = '0;
    arb_dst_hdr_val       = 1'b0;
    arb_dst_src_ip_addr   = '0;
    arb_dst_dst_ip_addr   = '0;
    arb_dst_tcp_len       = '0;
    arb_dst_tcp_hdr       = '0;
    arb_dst_data_val      = 1'b0;
    arb_dst_data          = '0;
    arb_dst_data_last     = 1'b0;
    arb_dst_data_padbytes = '0;

    unique case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          grant_oh_nxt          = '0;
          grant_oh_nxt[win_idx] = 1'b1;
          grant_idx_nxt         = win_idx;
          state_nxt             = ST_HDR;
        end
      end

      ST_HDR: begin
        // A winner that drops hdr_val simply stalls here; no re-arbitration.
        arb_dst_hdr_val                 = src_arb_hdr_val[grant_idx_reg];
        arb_dst_src_ip_addr             = src_arb_src_ip_addr[grant_idx_reg];
        arb_dst_dst_ip_addr             = src_arb_dst_ip_addr[grant_idx_reg];
        arb_dst_tcp_len                 = src_arb_tcp_len[grant_idx_reg];
        arb_dst_tcp_hdr                 = hdr_sel;
        arb_src_hdr_rdy[grant_idx_reg]  = dst_arb_hdr_rdy;
        if (src_arb_hdr_val[grant_idx_reg] && dst_arb_hdr_rdy) begin
          if (payload_len == '0) begin
            state_nxt    = ST_IDLE;
            grant_oh_nxt = '0;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
            rr_ptr_nxt   = (int'(grant_idx_reg) == NUM_SRC - 1) ? '0
                                                                : grant_idx_reg + 1'b1;
`endif
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        arb_dst_data_val                = src_arb_data_val[grant_idx_reg];
        arb_dst_data                    = src_arb_data[grant_idx_reg];
        arb_dst_data_last               = src_arb_data_last[grant_idx_reg];
        arb_dst_data_padbytes           = src_arb_data_padbytes[grant_idx_reg];
        arb_src_data_rdy[grant_idx_reg] = dst_arb_data_rdy;
        if (src_arb_data_val[grant_idx_reg] && dst_arb_data_rdy &&
            src_arb_data_last[grant_idx_reg]) begin
          state_nxt    = ST_IDLE;
          grant_oh_nxt = '0;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
          rr_ptr_nxt   = (int'(grant_idx_reg) == NUM_SRC - 1) ? '0
                                                              : grant_idx_reg + 1'b1;
`endif
        end
      end

      default: begin
        state_nxt    = ST_IDLE;
        grant_oh_nxt = '0;
      end
    endcase
  end

endmodule
